// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS payload LSB first, optional parity, STOP_BITS stop bits.
// Build option: define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) after the payload.
module uart_tx_cfg #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send_go,
  output logic                 uart_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Reject configurations the datapath cannot represent
  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("uart_tx_cfg: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;

  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  state_t               state;
  state_t               state_n;
  logic [CNT_W-1:0]     div_cnt;
  logic [CNT_W-1:0]     div_n;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_n;
  logic [BIT_W-1:0]     bit_inc;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] data_n;
  logic                 tx_n;
  logic                 busy_n;
  logic                 done_n;
  logic                 div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign bit_inc  = bit_cnt + BIT_W'(1);

  // Next-state and next-output logic; every register update is decided here
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    data_n  = data_q;
    tx_n    = uart_tx;
    busy_n  = tx_busy;
    done_n  = 1'b0;

    if (state != IDLE) begin
      div_n = div_wrap ? '0 : div_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        div_n  = '0;
        bit_n  = '0;
        if (send_go) begin
          data_n  = data_in;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end

      START: begin
        if (div_wrap) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = data_q[0];
        end
      end

      DATA: begin
        if (div_wrap) begin
          if (bit_cnt == DATA_LAST) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = (^data_q) ^ 1'(PARITY_ODD);
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_inc;
            tx_n  = data_q[bit_inc];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (div_wrap) begin
          state_n = STOP;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
`endif

      STOP: begin
        tx_n = 1'b1;
        if (div_wrap) begin
          // bit_cnt is reused to count stop-bit periods
          if (bit_cnt == STOP_LAST) begin
            state_n = IDLE;
            bit_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_inc;
          end
        end
      end

      default: begin
        state_n = IDLE;
        div_n   = '0;
        bit_n   = '0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      data_q  <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      data_q  <= data_n;
      uart_tx <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: two instances (8N1 and 5-bit/2-stop) checked every cycle against a frame-level model.
module tb_uart_tx_cfg;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [15:0] EXP_A5 = 16'(11'b01010010101);
  localparam logic [15:0] EXP_13 = 16'(9'b011001011);
  localparam logic [15:0] EXP_05 = 16'(9'b010100111);
  localparam logic [15:0] EXP_81 = 16'(11'b01000000101);
`else
  localparam int PB = 0;
  localparam logic [15:0] EXP_A5 = 16'(10'b0101001011);
  localparam logic [15:0] EXP_13 = 16'(8'b01100111);
  localparam logic [15:0] EXP_05 = 16'(8'b01010011);
  localparam logic [15:0] EXP_81 = 16'(10'b0100000011);
`endif
  localparam int NB_A = 1 + 8 + PB + 1;
  localparam int NB_B = 1 + 5 + PB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go [2];
  logic [7:0] din_a;
  logic [4:0] din_b;
  logic       tx [2];
  logic       busy [2];
  logic       done [2];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt [2];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .data_in(din_a), .send_go(go[0]),
    .uart_tx(tx[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
    .clk(clk), .rst(rst), .data_in(din_b), .send_go(go[1]),
    .uart_tx(tx[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  // Frame-level model: a frame is a list of line bits, each held DIV clocks
  logic m_busy [2];
  int   m_t [2];
  int   m_nb [2];
  logic m_bits [2][16];
  logic exp_tx [2];
  logic exp_busy [2];
  logic exp_done [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]   = 1'b0;
        m_t[i]      = 0;
        exp_tx[i]   = 1'b1;
        exp_busy[i] = 1'b0;
        exp_done[i] = 1'b0;
      end else begin
        exp_done[i] = 1'b0;
        if (!m_busy[i] && go[i]) begin
          logic [7:0] d;
          int db, sb, n;
          d  = (i == 0) ? din_a : {3'b000, din_b};
          db = (i == 0) ? 8 : 5;
          sb = (i == 0) ? 1 : 2;
          m_bits[i][0] = 1'b0;
          for (int j = 0; j < db; j++) m_bits[i][1 + j] = d[j];
          n = 1 + db;
`ifdef UART_TX_PARITY_EN
          m_bits[i][n] = (^d) ^ (i == 1);
          n++;
`endif
          for (int s = 0; s < sb; s++) m_bits[i][n + s] = 1'b1;
          m_nb[i]   = n + sb;
          m_t[i]    = 0;
          m_busy[i] = 1'b1;
        end else if (m_busy[i]) begin
          m_t[i]++;
          if (m_t[i] == m_nb[i] * DIV) begin
            m_busy[i]   = 1'b0;
            exp_done[i] = 1'b1;
          end
        end
        exp_tx[i]   = m_busy[i] ? m_bits[i][m_t[i] / DIV] : 1'b1;
        exp_busy[i] = m_busy[i];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tx_u%0d", i), int'(tx[i]), int'(exp_tx[i]));
      check($sformatf("busy_u%0d", i), int'(busy[i]), int'(exp_busy[i]));
      check($sformatf("done_u%0d", i), int'(done[i]), int'(exp_done[i]));
      if (done[i] === 1'b1) done_cnt[i]++;
    end
  end

  task automatic launch(input int inst, input logic [7:0] d);
    @(negedge clk);
    if (inst == 0) din_a = d;
    else din_b = d[4:0];
    go[inst] = 1'b1;
    @(negedge clk);
    go[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int limit, inout int j);
    while (done[inst] !== 1'b1 && j < limit) begin
      @(negedge clk);
      j++;
    end
  endtask

  task automatic run_frame(input int inst, input logic [7:0] d, input logic [15:0] want, input int nb);
    int j;
    int c0;
    c0 = done_cnt[inst];
    launch(inst, d);
    j = 0;
    for (int k = 0; k < nb; k++) begin
      repeat ((k == 0) ? 5 : 10) @(negedge clk);
      j += (k == 0) ? 5 : 10;
      check($sformatf("line_bit%0d_u%0d", k, inst), int'(tx[inst]), int'(want[nb - 1 - k]));
    end
    wait_done(inst, nb * DIV + 20, j);
    check($sformatf("frame_len_u%0d", inst), j, nb * DIV);
    @(negedge clk);
    check($sformatf("done_pulses_u%0d", inst), done_cnt[inst] - c0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int c0;
    go[0] = 1'b0;
    go[1] = 1'b0;
    din_a = '0;
    din_b = '0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_a", int'(tx[0]), 1);
    check("rst_busy_a", int'(busy[0]), 0);
    check("rst_done_a", int'(done[0]), 0);
    check("rst_tx_b", int'(tx[1]), 1);
    rst = 1'b0;

    // 8N1 0xA5 (with parity build: even parity bit 0)
    run_frame(0, 8'hA5, EXP_A5, NB_A);
    // 5 data bits, 2 stops, 0x13
    run_frame(1, 8'h13, EXP_13, NB_B);
    run_frame(1, 8'h05, EXP_05, NB_B);

    // Request during a frame is ignored
    c0 = done_cnt[0];
    launch(0, 8'h5A);
    j = 0;
    repeat (29) @(negedge clk);
    j += 29;
    din_a = 8'h00;
    go[0] = 1'b1;
    @(negedge clk);
    j++;
    go[0] = 1'b0;
    wait_done(0, NB_A * DIV + 20, j);
    check("ignored_go_len", j, NB_A * DIV);
    @(negedge clk);
    check("ignored_go_pulses", done_cnt[0] - c0, 1);

    // Back-to-back: new request in the tx_done cycle
    c0 = done_cnt[0];
    launch(0, 8'hC3);
    j = 0;
    wait_done(0, NB_A * DIV + 20, j);
    check("b2b_first_len", j, NB_A * DIV);
    din_a = 8'h3C;
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    check("b2b_start_tx", int'(tx[0]), 0);
    check("b2b_start_busy", int'(busy[0]), 1);
    j = 0;
    wait_done(0, NB_A * DIV + 20, j);
    check("b2b_second_len", j, NB_A * DIV);
    @(negedge clk);
    check("b2b_pulses", done_cnt[0] - c0, 2);

    // Asynchronous reset mid-frame
    c0 = done_cnt[0];
    launch(0, 8'h96);
    repeat (45) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", int'(tx[0]), 1);
    check("async_rst_busy", int'(busy[0]), 0);
    check("async_rst_done", int'(done[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_done", done_cnt[0] - c0, 0);
    run_frame(0, 8'h81, EXP_81, NB_A);

    repeat (5) @(negedge clk);
    check("idle_tx_a", int'(tx[0]), 1);
    check("idle_busy_b", int'(busy[1]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
